// File: rtl/braille_cell_sequencer.sv
// ============================================================================
// braille_cell_sequencer
// ----------------------------------------------------------------------------
// Turns a stream of 8-bit ASCII characters into timed one-hot letter cells for
// the text-to-braille encoder. Characters are buffered in a small FIFO. Each
// cell is held on 'alp' for DWELL_CYCLES clocks. The bus is then blanked for
// GAP_CYCLES clocks, so the actuator can settle and the reader can tell
// consecutive cells apart.
//
// Optional feature macro: BRAILLE_SPACE_EN
//   defined   - ASCII space (0x20) is accepted as a blank cell (index 26). It
//               is timed like a letter, with alp = 0 and cell_active = 1.
//   undefined - ASCII space is treated as an unsupported character.
//
// Parameters
//   DWELL_CYCLES  clocks a cell is held on alp (>= 1)
//   GAP_CYCLES    clocks of blank between cells (0 = no gap)
//   FIFO_DEPTH    character buffer entries (power of 2, >= 2)
//   CNT_W         timer width, must hold max(DWELL_CYCLES, GAP_CYCLES)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_char is valid this cycle
//   in_ready     out  FIFO can accept (not full)
//   in_char      in   ASCII character
//   alp          out  one-hot letter, bit0 = 'a' ... bit25 = 'z'
//   cell_active  out  high while a cell is displayed
//   busy         out  high unless idle with an empty FIFO
//   err_pulse    out  one-cycle pulse when an unsupported char was dropped
//   fifo_count   out  entries currently buffered
// ============================================================================
module braille_cell_sequencer #(
   parameter int DWELL_CYCLES = 1000,
   parameter int GAP_CYCLES   = 100,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_char,
   output logic [25:0]                   alp,
   output logic                          cell_active,
   output logic                          busy,
   output logic                          err_pulse,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(FIFO_DEPTH);

   // Index 26 is the blank cell. Anything at or above it drives no letter line.
   localparam logic [4:0] SPACE_IDX = 5'd26;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DWELL = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  timer;
   logic [CNT_W-1:0]  timer_next;
   logic [25:0]       alp_next;
   logic              active_next;
   logic [4:0]        cur_idx;
   logic [4:0]        cur_idx_next;

   logic [4:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [4:0]        head;

   logic              char_ok;
   logic [4:0]        char_idx;
   logic              push_fire;
   logic              push_en;
   logic              pop_en;

   // Classify the incoming character and fold it to a letter index.
   // Both 'a'..'z' (0x61..0x7A) and 'A'..'Z' (0x41..0x5A) have 1..26 in their
   // low five bits, so a single subtract folds upper and lower case together.
   always_comb begin
      char_ok  = 1'b0;
      char_idx = '0;
      if ((in_char >= 8'h61 && in_char <= 8'h7A) ||
          (in_char >= 8'h41 && in_char <= 8'h5A)) begin
         char_ok  = 1'b1;
         char_idx = in_char[4:0] - 5'd1;
      end
`ifdef BRAILLE_SPACE_EN
      else if (in_char == 8'h20) begin
         char_ok  = 1'b1;
         char_idx = SPACE_IDX;
      end
`else
      else begin
         char_ok  = 1'b0;
         char_idx = '0;
      end
`endif
   end

   // Every handshake consumes the character. Only supported characters reach
   // the buffer, so an unsupported one never stalls the stream.
   assign push_fire = in_valid & in_ready;
   assign push_en   = push_fire & char_ok;

   // in_ready comes only from the registered count. A pop in the same cycle
   // therefore frees space for a push on the following cycle, not this one.
   assign in_ready   = (count != FULL_COUNT);
   assign fifo_count = count;
   assign head       = mem[rd_ptr];
   assign busy       = !((state == IDLE) && (count == '0));

   // Buffer storage. This holds data only and needs no reset; the pointers
   // and the count decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= char_idx;
      end
   end

   // Buffer pointers, occupancy count and the dropped-character pulse.
   // The pointers wrap naturally because FIFO_DEPTH is a power of two.
   // A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= push_fire & ~char_ok;
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Cell sequencing: the state register together with the registered
   // outputs it owns. alp and cell_active are registered here, so they can
   // only change on a clock edge and never glitch toward the encoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         alp         <= '0;
         cell_active <= 1'b0;
         cur_idx     <= '0;
      end else begin
         state       <= state_next;
         timer       <= timer_next;
         alp         <= alp_next;
         cell_active <= active_next;
         cur_idx     <= cur_idx_next;
      end
   end

   // Next-state logic for IDLE -> LOAD -> DWELL -> GAP -> IDLE.
   // IDLE pops the head entry and latches its index. LOAD turns the index
   // into the one-hot pattern and starts the dwell timer. DWELL counts down
   // to zero and then blanks the bus. GAP counts the blank time.
   // alp is written only on entry to DWELL (from LOAD) and on exit from DWELL.
   // Every other state keeps it at zero, so the bus is never multi-hot.
   always_comb begin
      state_next   = state;
      timer_next   = timer;
      alp_next     = alp;
      active_next  = cell_active;
      cur_idx_next = cur_idx;
      pop_en       = 1'b0;

      case (state)
         IDLE: begin
            alp_next    = '0;
            active_next = 1'b0;
            if (count != '0) begin
               pop_en       = 1'b1;
               cur_idx_next = head;
               state_next   = LOAD;
            end
         end

         LOAD: begin
            if (cur_idx < SPACE_IDX) begin
               alp_next = 26'd1 << cur_idx;
            end else begin
               alp_next = '0;
            end
            active_next = 1'b1;
            timer_next  = DWELL_LOAD;
            state_next  = DWELL;
         end

         DWELL: begin
            if (timer == '0) begin
               alp_next    = '0;
               active_next = 1'b0;
               if (GAP_CYCLES > 0) begin
                  timer_next = GAP_LOAD;
                  state_next = GAP;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         GAP: begin
            alp_next    = '0;
            active_next = 1'b0;
            if (timer == '0) begin
               state_next = IDLE;
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         default: begin
            alp_next    = '0;
            active_next = 1'b0;
            state_next  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_braille_cell_sequencer.sv
// ============================================================================
// tb_braille_cell_sequencer
// ----------------------------------------------------------------------------
// Directed testbench for braille_cell_sequencer. The DUT is built with
// DWELL = 4, GAP = 2, FIFO_DEPTH = 4. A background monitor records every
// displayed cell (alp at cell start, dwell length, blank run before it) and
// checks that alp is blank outside cells and stable inside them. Each test
// task drives its own scenario and compares against hand-computed values.
// ============================================================================
module tb_braille_cell_sequencer;

   localparam int DWELL = 4;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_char;
   logic [25:0] alp;
   logic        cell_active;
   logic        busy;
   logic        err_pulse;
   logic [2:0]  fifo_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [25:0] cell_q [$];
   int          len_q  [$];
   int          gap_q  [$];
   logic        prev_active;
   int          act_len;
   int          low_run;

   braille_cell_sequencer #(
      .DWELL_CYCLES (DWELL),
      .GAP_CYCLES   (GAP),
      .FIFO_DEPTH   (DEPTH),
      .CNT_W        (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_char     (in_char),
      .alp         (alp),
      .cell_active (cell_active),
      .busy        (busy),
      .err_pulse   (err_pulse),
      .fifo_count  (fifo_count)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Background cell monitor, sampled on the falling edge away from the
   // active edge. It logs each cell and checks that the bus is blank
   // outside cells and steady inside them.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_active = 1'b0;
         act_len     = 0;
         low_run     = 0;
      end else begin
         if (cell_active) begin
            if (!prev_active) begin
               cell_q.push_back(alp);
               gap_q.push_back(low_run);
               act_len = 0;
            end
            act_len++;
            low_run = 0;
            n_compared++;
            if (alp !== cell_q[cell_q.size()-1] || $countones(alp) > 1) begin
               n_mismatched++;
               $display("[TB] FAIL mon_alp_hold: observed %0h, expected steady one-hot %0h", alp, cell_q[cell_q.size()-1]);
            end
         end else begin
            if (prev_active) begin
               len_q.push_back(act_len);
            end
            low_run++;
            n_compared++;
            if (alp !== 26'h0) begin
               n_mismatched++;
               $display("[TB] FAIL mon_alp_blank: observed %0h, expected 0", alp);
            end
         end
         prev_active = cell_active;
      end
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_monitor();
      cell_q.delete();
      len_q.delete();
      gap_q.delete();
   endtask

   // Drive one character for exactly one clock edge (caller knows in_ready)
   task automatic applyStimulus(input logic [7:0] c);
      in_valid = 1'b1;
      in_char  = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < max_cycles) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_active(input int max_cycles, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < max_cycles) begin
         if (cell_active === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   // Power-up reset state
   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_char  = 8'h00;
      tick();
      tick();
      n_compared++; if (alp !== 26'h0)        begin n_mismatched++; $display("[TB] FAIL reset_alp: observed %0h, expected 0", alp); end
      n_compared++; if (cell_active !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_active: observed %0b, expected 0", cell_active); end
      n_compared++; if (err_pulse !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL reset_err: observed %0b, expected 0", err_pulse); end
      n_compared++; if (fifo_count !== 3'd0)  begin n_mismatched++; $display("[TB] FAIL reset_count: observed %0d, expected 0", fifo_count); end
      n_compared++; if (in_ready !== 1'b1)    begin n_mismatched++; $display("[TB] FAIL reset_ready: observed %0b, expected 1", in_ready); end
      n_compared++; if (busy !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL reset_busy: observed %0b, expected 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      n_compared++; if (busy !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL reset_idle_busy: observed %0b, expected 0", busy); end
   endtask

   // Single 'a': cycle-exact latency, dwell and gap
   task automatic test_single_char();
      clear_monitor();
      applyStimulus(8'h61);
      n_compared++; if (fifo_count !== 3'd1)  begin n_mismatched++; $display("[TB] FAIL single_count: observed %0d, expected 1", fifo_count); end
      n_compared++; if (busy !== 1'b1)        begin n_mismatched++; $display("[TB] FAIL single_busy: observed %0b, expected 1", busy); end
      tick();
      n_compared++; if (alp !== 26'h0)        begin n_mismatched++; $display("[TB] FAIL single_load_alp: observed %0h, expected 0", alp); end
      n_compared++; if (fifo_count !== 3'd0)  begin n_mismatched++; $display("[TB] FAIL single_pop_count: observed %0d, expected 0", fifo_count); end
      for (int i = 0; i < DWELL; i++) begin
         tick();
         n_compared++; if (alp !== 26'h1)        begin n_mismatched++; $display("[TB] FAIL single_dwell_alp[%0d]: observed %0h, expected 1", i, alp); end
         n_compared++; if (cell_active !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_dwell_active[%0d]: observed %0b, expected 1", i, cell_active); end
      end
      for (int i = 0; i < GAP; i++) begin
         tick();
         n_compared++; if (alp !== 26'h0)        begin n_mismatched++; $display("[TB] FAIL single_gap_alp[%0d]: observed %0h, expected 0", i, alp); end
         n_compared++; if (cell_active !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_gap_active[%0d]: observed %0b, expected 0", i, cell_active); end
         n_compared++; if (busy !== 1'b1)        begin n_mismatched++; $display("[TB] FAIL single_gap_busy[%0d]: observed %0b, expected 1", i, busy); end
      end
      tick();
      n_compared++; if (busy !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL single_busy_fall: observed %0b, expected 0", busy); end
   endtask

   // "Zb": case folding and ordering, with the gap between the cells
   task automatic test_case_fold_order();
      bit ok;
      clear_monitor();
      applyStimulus(8'h5A);
      applyStimulus(8'h62);
      wait_idle(100, ok);
      n_compared++; if (ok !== 1'b1)          begin n_mismatched++; $display("[TB] FAIL fold_timeout: observed busy %0b, expected 0", busy); end
      n_compared++; if (cell_q.size() != 2)   begin n_mismatched++; $display("[TB] FAIL fold_cells: observed %0d, expected 2", cell_q.size()); end
      if (cell_q.size() >= 2 && len_q.size() >= 2) begin
         n_compared++; if (cell_q[0] !== 26'h2000000) begin n_mismatched++; $display("[TB] FAIL fold_cell0: observed %0h, expected 2000000", cell_q[0]); end
         n_compared++; if (cell_q[1] !== 26'h2)       begin n_mismatched++; $display("[TB] FAIL fold_cell1: observed %0h, expected 2", cell_q[1]); end
         n_compared++; if (len_q[0] != DWELL)         begin n_mismatched++; $display("[TB] FAIL fold_len0: observed %0d, expected %0d", len_q[0], DWELL); end
         n_compared++; if (gap_q[1] != GAP + 2)       begin n_mismatched++; $display("[TB] FAIL fold_gap: observed %0d, expected %0d", gap_q[1], GAP + 2); end
      end
   endtask

   // Six chars with in_valid held: FIFO fills, in_ready drops, nothing lost
   task automatic test_full_fifo();
      logic [7:0]  seq [6]       = '{8'h66, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B};
      logic [25:0] exp_cells [6] = '{26'h20, 26'h40, 26'h80, 26'h100, 26'h200, 26'h400};
      int  idx;
      int  guard;
      bit  saw_full;
      bit  acc;
      bit  ok;
      clear_monitor();
      idx      = 0;
      guard    = 0;
      saw_full = 1'b0;
      in_valid = 1'b1;
      in_char  = seq[0];
      while (idx < 6 && guard < 200) begin
         if (in_ready === 1'b0) begin
            if (!saw_full) begin
               n_compared++; if (fifo_count !== 3'd4) begin n_mismatched++; $display("[TB] FAIL full_count: observed %0d, expected 4", fifo_count); end
            end
            saw_full = 1'b1;
         end
         acc = (in_ready === 1'b1);
         tick();
         guard++;
         if (acc) begin
            idx++;
            if (idx < 6) in_char = seq[idx];
         end
      end
      in_valid = 1'b0;
      n_compared++; if (idx != 6)             begin n_mismatched++; $display("[TB] FAIL full_accept: observed %0d accepted, expected 6", idx); end
      n_compared++; if (saw_full !== 1'b1)    begin n_mismatched++; $display("[TB] FAIL full_ready_low: observed %0b, expected 1", saw_full); end
      wait_idle(400, ok);
      n_compared++; if (ok !== 1'b1)          begin n_mismatched++; $display("[TB] FAIL full_timeout: observed busy %0b, expected 0", busy); end
      n_compared++; if (cell_q.size() != 6)   begin n_mismatched++; $display("[TB] FAIL full_cells: observed %0d, expected 6", cell_q.size()); end
      for (int i = 0; i < 6; i++) begin
         if (i < cell_q.size()) begin
            n_compared++; if (cell_q[i] !== exp_cells[i]) begin n_mismatched++; $display("[TB] FAIL full_cell[%0d]: observed %0h, expected %0h", i, cell_q[i], exp_cells[i]); end
         end
         if (i < len_q.size()) begin
            n_compared++; if (len_q[i] != DWELL) begin n_mismatched++; $display("[TB] FAIL full_len[%0d]: observed %0d, expected %0d", i, len_q[i], DWELL); end
         end
      end
   endtask

   // '1' then 'd': the digit is dropped with an error pulse
   task automatic test_invalid_char();
      bit ok;
      clear_monitor();
      in_valid = 1'b1;
      in_char  = 8'h31;
      tick();
      n_compared++; if (err_pulse !== 1'b1)   begin n_mismatched++; $display("[TB] FAIL inval_err: observed %0b, expected 1", err_pulse); end
      n_compared++; if (fifo_count !== 3'd0)  begin n_mismatched++; $display("[TB] FAIL inval_count: observed %0d, expected 0", fifo_count); end
      in_char = 8'h64;
      tick();
      in_valid = 1'b0;
      n_compared++; if (err_pulse !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL inval_err_fall: observed %0b, expected 0", err_pulse); end
      n_compared++; if (fifo_count !== 3'd1)  begin n_mismatched++; $display("[TB] FAIL inval_d_count: observed %0d, expected 1", fifo_count); end
      wait_idle(100, ok);
      n_compared++; if (ok !== 1'b1)          begin n_mismatched++; $display("[TB] FAIL inval_timeout: observed busy %0b, expected 0", busy); end
      n_compared++; if (cell_q.size() != 1)   begin n_mismatched++; $display("[TB] FAIL inval_cells: observed %0d, expected 1", cell_q.size()); end
      if (cell_q.size() >= 1) begin
         n_compared++; if (cell_q[0] !== 26'h8) begin n_mismatched++; $display("[TB] FAIL inval_cell0: observed %0h, expected 8", cell_q[0]); end
      end
   endtask

   // 'a',' ','b': blank timed cell when space is enabled, else dropped
   task automatic test_space_cell();
      bit ok;
      clear_monitor();
      applyStimulus(8'h61);
      applyStimulus(8'h20);
`ifdef BRAILLE_SPACE_EN
      n_compared++; if (err_pulse !== 1'b0)   begin n_mismatched++; $display("[TB] FAIL space_err: observed %0b, expected 0", err_pulse); end
`else
      n_compared++; if (err_pulse !== 1'b1)   begin n_mismatched++; $display("[TB] FAIL space_err: observed %0b, expected 1", err_pulse); end
`endif
      applyStimulus(8'h62);
      wait_idle(200, ok);
      n_compared++; if (ok !== 1'b1)          begin n_mismatched++; $display("[TB] FAIL space_timeout: observed busy %0b, expected 0", busy); end
`ifdef BRAILLE_SPACE_EN
      n_compared++; if (cell_q.size() != 3)   begin n_mismatched++; $display("[TB] FAIL space_cells: observed %0d, expected 3", cell_q.size()); end
      if (cell_q.size() >= 3 && len_q.size() >= 3) begin
         n_compared++; if (cell_q[0] !== 26'h1) begin n_mismatched++; $display("[TB] FAIL space_cell0: observed %0h, expected 1", cell_q[0]); end
         n_compared++; if (cell_q[1] !== 26'h0) begin n_mismatched++; $display("[TB] FAIL space_cell1: observed %0h, expected 0", cell_q[1]); end
         n_compared++; if (cell_q[2] !== 26'h2) begin n_mismatched++; $display("[TB] FAIL space_cell2: observed %0h, expected 2", cell_q[2]); end
         n_compared++; if (len_q[1] != DWELL)   begin n_mismatched++; $display("[TB] FAIL space_len1: observed %0d, expected %0d", len_q[1], DWELL); end
      end
`else
      n_compared++; if (cell_q.size() != 2)   begin n_mismatched++; $display("[TB] FAIL space_cells: observed %0d, expected 2", cell_q.size()); end
      if (cell_q.size() >= 2) begin
         n_compared++; if (cell_q[0] !== 26'h1) begin n_mismatched++; $display("[TB] FAIL space_cell0: observed %0h, expected 1", cell_q[0]); end
         n_compared++; if (cell_q[1] !== 26'h2) begin n_mismatched++; $display("[TB] FAIL space_cell1: observed %0h, expected 2", cell_q[1]); end
         n_compared++; if (gap_q[1] != GAP + 2) begin n_mismatched++; $display("[TB] FAIL space_gap: observed %0d, expected %0d", gap_q[1], GAP + 2); end
      end
`endif
   endtask

   // Reset asserted in the middle of the 'c' cell while 'd' is buffered
   task automatic test_reset_mid_cell();
      bit ok;
      clear_monitor();
      applyStimulus(8'h63);
      applyStimulus(8'h64);
      wait_active(20, ok);
      n_compared++; if (ok !== 1'b1)          begin n_mismatched++; $display("[TB] FAIL rstmid_start: observed active %0b, expected 1", cell_active); end
      tick();
      n_compared++; if (alp !== 26'h4)        begin n_mismatched++; $display("[TB] FAIL rstmid_alp_pre: observed %0h, expected 4", alp); end
      n_compared++; if (fifo_count !== 3'd1)  begin n_mismatched++; $display("[TB] FAIL rstmid_count_pre: observed %0d, expected 1", fifo_count); end
      #2;
      rst_n = 1'b0;
      #1;
      n_compared++; if (alp !== 26'h0)        begin n_mismatched++; $display("[TB] FAIL rstmid_alp: observed %0h, expected 0", alp); end
      n_compared++; if (cell_active !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_active: observed %0b, expected 0", cell_active); end
      n_compared++; if (fifo_count !== 3'd0)  begin n_mismatched++; $display("[TB] FAIL rstmid_count: observed %0d, expected 0", fifo_count); end
      n_compared++; if (busy !== 1'b0)        begin n_mismatched++; $display("[TB] FAIL rstmid_busy: observed %0b, expected 0", busy); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_compared++; if (alp !== 26'h0)     begin n_mismatched++; $display("[TB] FAIL rstmid_after_alp[%0d]: observed %0h, expected 0", i, alp); end
         n_compared++; if (busy !== 1'b0)     begin n_mismatched++; $display("[TB] FAIL rstmid_after_busy[%0d]: observed %0b, expected 0", i, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_case_fold_order();
      test_full_fifo();
      test_invalid_char();
      test_space_cell();
      test_reset_mid_cell();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
